// File: rtl/activity_counter.sv
// Rising-edge activity counter bank for gate-level power estimation.
// Counts 0->1 transitions per probe channel; counters are read back over a req/ack port.
module activity_counter #(
    parameter int NCH   = 8,
    parameter int CW    = 16,
    parameter int SELW  = 3,
    parameter bit RDCLR = 1'b0
) (
    input  logic            C,
    input  logic            RN,
    input  logic [NCH-1:0]  PROBE,
    input  logic            EN,
    input  logic            CLR,
    input  logic            RD_REQ,
    input  logic [SELW-1:0] RD_SEL,
    output logic            RD_ACK,
    output logic [CW-1:0]   RD_DATA,
    output logic            RD_SAT,
    output logic            OVF_ANY,
    output logic [1:0]      dbg_state
);
    // Handshake: RD_REQ is a level held by the requester until it sees RD_ACK, a
    // one-cycle pulse marking RD_DATA/RD_SAT valid; RD_REQ must then be sampled low
    // before another request is accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2} rd_state_t;

    rd_state_t      state;
    logic [NCH-1:0] prev;
    logic [NCH-1:0] edge_v;
    logic [NCH-1:0] sat;
    logic [CW-1:0]  cnt [NCH];
    logic [CW-1:0]  sel_cnt;
    logic           sel_sat;
    logic           capture;

    assign edge_v    = PROBE & ~prev;
    assign capture   = (state == IDLE) && RD_REQ;
    assign dbg_state = state;

    // Out-of-range selects match no channel and read back as zero.
    always_comb begin
        sel_cnt = '0;
        sel_sat = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (RD_SEL == SELW'(i)) begin
                sel_cnt = cnt[i];
                sel_sat = sat[i];
            end
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            prev    <= '1;
            sat     <= '0;
            OVF_ANY <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            prev <= PROBE;
            if (CLR) begin
                sat     <= '0;
                OVF_ANY <= 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (RDCLR && capture && (RD_SEL == SELW'(i))) begin
                        cnt[i] <= (EN && edge_v[i]) ? CW'(1) : '0;
                        sat[i] <= 1'b0;
                    end else if (EN && edge_v[i]) begin
                        // An edge arriving at all-ones is lost; flag it instead.
                        if (cnt[i] == '1) begin
                            sat[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
                OVF_ANY <= OVF_ANY | (|sat);
            end
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            RD_ACK  <= 1'b0;
            RD_DATA <= '0;
            RD_SAT  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (RD_REQ) begin
                        RD_ACK  <= 1'b1;
                        RD_DATA <= sel_cnt;
                        RD_SAT  <= sel_sat;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    RD_ACK <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (!RD_REQ) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    RD_ACK <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
